egg_timer_control: RTL and testbench

Front-panel sequencing controller for the egg timer. It turns single-cycle button pulses into the programmed cook time (four BCD digits), a one-cycle `load` strobe and the `main_enable` run gate for the `time_count` down-counter. It reacts to the counter's `done` flag by driving a timed, 1 Hz-toggling alarm output. It sits between the button debouncers and `time_count`, and shares `clk`, `reset` and the `pulse_1s` tick from the `clock_divider` instance.

---
 rtl/egg_timer_control.sv | 132 +++++++++++++
 tb/tb_egg_timer_control.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/egg_timer_control.sv
// egg_timer_control: front-panel sequencer turning button pulses into a BCD cook time, load/run gating and a timed alarm.
module egg_timer_control #(
  parameter int ALARM_SECS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pulse_1s,
  input  logic       btn_start,
  input  logic       btn_clear,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       done,
  output logic [3:0] seconds_prog,
  output logic [3:0] tens_seconds_prog,
  output logic [3:0] minutes_prog,
  output logic [3:0] tens_minutes_prog,
  output logic       load,
  output logic       main_enable,
  output logic       alarm,
  output logic [1:0] digit_sel,
  output logic [2:0] state
);
  typedef enum logic [2:0] {IDLE = 3'd0, SET = 3'd1, LOAD = 3'd2, RUN = 3'd3, PAUSE = 3'd4, ALARM = 3'd5} state_t;
  state_t st;
  logic [7:0] alarm_cnt;
  logic clr, sta, se, inc, nz;
  // only the highest-priority pulse survives: clear > start > set > inc
  assign clr = btn_clear;
  assign sta = btn_start & ~btn_clear;
  assign se = btn_set & ~btn_start & ~btn_clear;
  assign inc = btn_inc & ~btn_set & ~btn_start & ~btn_clear;
  assign nz = |{seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog};
  assign state = st;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st <= IDLE;
      seconds_prog <= 4'd0;
      tens_seconds_prog <= 4'd0;
      minutes_prog <= 4'd0;
      tens_minutes_prog <= 4'd0;
      digit_sel <= 2'd0;
      load <= 1'b0;
      main_enable <= 1'b0;
      alarm <= 1'b0;
      alarm_cnt <= 8'd0;
    end else begin
      load <= 1'b0;
      case (st)
        IDLE: begin
          if (clr) begin
            seconds_prog <= 4'd0;
            tens_seconds_prog <= 4'd0;
            minutes_prog <= 4'd0;
            tens_minutes_prog <= 4'd0;
          end else if (sta && nz) begin
            st <= LOAD;
            load <= 1'b1;
          end else if (se) begin
            st <= SET;
            digit_sel <= 2'd0;
          end
        end
        SET: begin
          if (clr) begin
            st <= IDLE;
            digit_sel <= 2'd0;
            seconds_prog <= 4'd0;
            tens_seconds_prog <= 4'd0;
            minutes_prog <= 4'd0;
            tens_minutes_prog <= 4'd0;
          end else if (sta && nz) begin
            st <= LOAD;
            load <= 1'b1;
            digit_sel <= 2'd0;
          end else if (se) begin
            st <= (digit_sel == 2'd3) ? IDLE : SET;
            digit_sel <= digit_sel + 2'd1;
          end else if (inc) begin
            case (digit_sel)
              2'd0: seconds_prog <= (seconds_prog >= 4'd9) ? 4'd0 : seconds_prog + 4'd1;
              2'd1: tens_seconds_prog <= (tens_seconds_prog >= 4'd5) ? 4'd0 : tens_seconds_prog + 4'd1;
              2'd2: minutes_prog <= (minutes_prog >= 4'd9) ? 4'd0 : minutes_prog + 4'd1;
              default: tens_minutes_prog <= (tens_minutes_prog >= 4'd5) ? 4'd0 : tens_minutes_prog + 4'd1;
            endcase
          end
        end
        LOAD: begin
          st <= RUN;
          main_enable <= 1'b1;
        end
        RUN: begin
          if (clr) begin
            st <= IDLE;
            main_enable <= 1'b0;
          end else if (sta) begin
            st <= PAUSE;
            main_enable <= 1'b0;
          end else if (done) begin
            st <= ALARM;
            main_enable <= 1'b0;
            alarm <= 1'b1;
            alarm_cnt <= 8'd0;
          end
        end
        PAUSE: begin
          if (clr) st <= IDLE;
          else if (sta) begin
            st <= RUN;
            main_enable <= 1'b1;
          end
        end
        ALARM: begin
          if (clr || sta) begin
            st <= IDLE;
            alarm <= 1'b0;
          end else if (pulse_1s) begin
            alarm_cnt <= alarm_cnt + 8'd1;
            if (alarm_cnt + 8'd1 == 8'(ALARM_SECS)) begin
              st <= IDLE;
              alarm <= 1'b0;
            end else alarm <= ~alarm;
          end
        end
        default: begin
          st <= IDLE;
          main_enable <= 1'b0;
          alarm <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_egg_timer_control.sv
// tb_egg_timer_control: directed stimulus pushes expected outputs into a queue; a monitor pops and compares.
module tb_egg_timer_control;
  logic clk = 0, reset = 0, pulse_1s = 0, btn_start = 0, btn_clear = 0, btn_set = 0, btn_inc = 0, done = 0;
  logic [3:0] s, ts, m, tm;
  logic load, main_enable, alarm;
  logic [1:0] digit_sel;
  logic [2:0] state;
  logic [23:0] act;
  int cyc = 0, tests = 0, fails = 0;
  typedef struct {int due; string nm; logic [23:0] exp;} ent_t;
  ent_t q[$];
  ent_t x;
  localparam logic [2:0] I = 3'd0, S = 3'd1, L = 3'd2, R = 3'd3, P = 3'd4, A = 3'd5;
  localparam logic [3:0] NONE = 4'b0000, CLR = 4'b1000, STA = 4'b0100, SETB = 4'b0010, INC = 4'b0001;

  egg_timer_control #(.ALARM_SECS(3)) dut (
    .clk(clk), .reset(reset), .pulse_1s(pulse_1s), .btn_start(btn_start), .btn_clear(btn_clear),
    .btn_set(btn_set), .btn_inc(btn_inc), .done(done), .seconds_prog(s), .tens_seconds_prog(ts),
    .minutes_prog(m), .tens_minutes_prog(tm), .load(load), .main_enable(main_enable), .alarm(alarm),
    .digit_sel(digit_sel), .state(state));

  assign act = {state, tm, m, ts, s, digit_sel, load, main_enable, alarm};
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [23:0] e(input logic [2:0] st, input logic [15:0] d, input logic [1:0] sel,
                                    input logic l, input logic me, input logic a);
    return {st, d, sel, l, me, a};
  endfunction

  task automatic compare(input ent_t y);
    tests++;
    if (act !== y.exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", y.nm, act, y.exp, cyc);
    end
  endtask

  always @(negedge clk)
    while (q.size() > 0 && q[0].due >= 0 && q[0].due <= cyc) begin
      x = q.pop_front();
      if (x.due < cyc) begin
        tests++;
        fails++;
        $display("FAIL %s: missed, due cycle %0d now %0d", x.nm, x.due, cyc);
      end else compare(x);
    end

  // asynchronous reset is checked without waiting for a clock edge
  always @(posedge reset) begin
    #1;
    if (q.size() > 0 && q[0].due < 0) compare(q.pop_front());
  end

  task automatic step(input string nm, input logic [3:0] b, input logic dn, input logic p, input logic [23:0] ex);
    @(posedge clk);
    #1;
    {btn_clear, btn_start, btn_set, btn_inc} = b;
    done = dn;
    pulse_1s = p;
    q.push_back('{due: cyc + 1, nm: nm, exp: ex});
  endtask

  task automatic idle_inputs();
    {btn_clear, btn_start, btn_set, btn_inc, done, pulse_1s} = 6'd0;
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    #1;
    idle_inputs();
    @(posedge clk);
    #2;
    q.push_back('{due: -1, nm: nm, exp: e(I, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0)});
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    #1;
    q.push_back('{due: -1, nm: "reset_init", exp: e(I, 16'h0000, 2'd0, 1'b0, 1'b0, 1'b0)});
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    step("enter_set", SETB, 0, 0, e(S, 16'h0000, 0, 0, 0, 0));
    for (int i = 1; i <= 4; i++) step("inc_s", INC, 0, 0, e(S, 16'(i), 0, 0, 0, 0));
    step("sel1", SETB, 0, 0, e(S, 16'h0004, 1, 0, 0, 0));
    for (int i = 1; i <= 3; i++) step("inc_ts", INC, 0, 0, e(S, 16'(16'h0004 + 16 * i), 1, 0, 0, 0));
    step("sel2", SETB, 0, 0, e(S, 16'h0034, 2, 0, 0, 0));
    for (int i = 1; i <= 2; i++) step("inc_m", INC, 0, 0, e(S, 16'(16'h0034 + 256 * i), 2, 0, 0, 0));
    step("sel3", SETB, 0, 0, e(S, 16'h0234, 3, 0, 0, 0));
    step("prog_1234", INC, 0, 0, e(S, 16'h1234, 3, 0, 0, 0));
    step("set_to_idle", SETB, 0, 0, e(I, 16'h1234, 0, 0, 0, 0));
    step("reenter_set", SETB, 0, 0, e(S, 16'h1234, 0, 0, 0, 0));
    for (int i = 1; i <= 10; i++) step("wrap_s", INC, 0, 0, e(S, {12'h123, 4'((4 + i) % 10)}, 0, 0, 0, 0));
    step("sel1b", SETB, 0, 0, e(S, 16'h1234, 1, 0, 0, 0));
    for (int i = 1; i <= 6; i++) step("wrap_ts", INC, 0, 0, e(S, 16'(16'h1204 + 16 * ((3 + i) % 6)), 1, 0, 0, 0));
    step("set_beats_inc", SETB | INC, 0, 0, e(S, 16'h1234, 2, 0, 0, 0));
    step("sel3b", SETB, 0, 0, e(S, 16'h1234, 3, 0, 0, 0));
    step("back_idle", SETB, 0, 0, e(I, 16'h1234, 0, 0, 0, 0));
    step("start_load", STA, 0, 0, e(L, 16'h1234, 0, 1, 0, 0));
    step("run_enable", NONE, 0, 0, e(R, 16'h1234, 0, 0, 1, 0));
    step("run_hold", NONE, 0, 0, e(R, 16'h1234, 0, 0, 1, 0));
    step("pause", STA, 0, 0, e(P, 16'h1234, 0, 0, 0, 0));
    step("pause_ign_done", NONE, 1, 0, e(P, 16'h1234, 0, 0, 0, 0));
    step("resume_noload", STA, 0, 0, e(R, 16'h1234, 0, 0, 1, 0));
    step("clr_beats_start", CLR | STA, 0, 0, e(I, 16'h1234, 0, 0, 0, 0));
    step("start2", STA, 0, 0, e(L, 16'h1234, 0, 1, 0, 0));
    step("run2", NONE, 1, 0, e(R, 16'h1234, 0, 0, 1, 0));
    step("start_beats_done", STA, 1, 0, e(P, 16'h1234, 0, 0, 0, 0));
    step("resume2", STA, 0, 0, e(R, 16'h1234, 0, 0, 1, 0));
    step("alarm_enter", NONE, 1, 0, e(A, 16'h1234, 0, 0, 0, 1));
    step("alarm_tick1", NONE, 0, 1, e(A, 16'h1234, 0, 0, 0, 0));
    step("alarm_hold", NONE, 0, 0, e(A, 16'h1234, 0, 0, 0, 0));
    step("alarm_tick2", NONE, 0, 1, e(A, 16'h1234, 0, 0, 0, 1));
    step("alarm_timeout", NONE, 0, 1, e(I, 16'h1234, 0, 0, 0, 0));
    step("start3", STA, 0, 0, e(L, 16'h1234, 0, 1, 0, 0));
    step("run3", NONE, 0, 0, e(R, 16'h1234, 0, 0, 1, 0));
    step("alarm_enter2", NONE, 1, 0, e(A, 16'h1234, 0, 0, 0, 1));
    step("alarm_clear", CLR, 1, 0, e(I, 16'h1234, 0, 0, 0, 0));
    step("start4", STA, 0, 0, e(L, 16'h1234, 0, 1, 0, 0));
    step("run4", NONE, 0, 0, e(R, 16'h1234, 0, 0, 1, 0));
    do_reset("reset_mid_run");
    step("clear_idle", CLR, 0, 0, e(I, 16'h0000, 0, 0, 0, 0));
    step("zero_start_idle", STA, 0, 0, e(I, 16'h0000, 0, 0, 0, 0));
    step("zero_start_after", NONE, 0, 0, e(I, 16'h0000, 0, 0, 0, 0));
    step("set_zero", SETB, 0, 0, e(S, 16'h0000, 0, 0, 0, 0));
    step("zero_start_set", STA, 0, 0, e(S, 16'h0000, 0, 0, 0, 0));
    step("inc_then_clear", INC, 0, 0, e(S, 16'h0001, 0, 0, 0, 0));
    step("clear_set", CLR, 0, 0, e(I, 16'h0000, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    while (q.size() > 0) begin
      x = q.pop_front();
      tests++;
      fails++;
      $display("FAIL %s: never checked, due cycle %0d", x.nm, x.due);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
